// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite fetch scheduler.
// The ROM and the two per-sprite line buffers are sized from these values.
package sprite_pkg;

    localparam int unsigned SPRITE_W = 16;
    localparam int unsigned SPRITE_H = 16;
    localparam int unsigned DATA_W   = 24;
    localparam logic [DATA_W-1:0] KEY_RGB = 24'hFF00FF;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t IDLE   = 2'd0;
    localparam fetch_state_t FETCH0 = 2'd1;
    localparam fetch_state_t FETCH1 = 2'd2;
    localparam fetch_state_t DRAIN  = 2'd3;

    typedef logic signed [10:0] coord_t;

    // Difference of two unsigned screen coordinates, widened so negatives are visible.
    function automatic coord_t coord_diff(input logic [9:0] a, input logic [9:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

endpackage

// File: rtl/sprite_line_buf.sv
// One sprite row of pixels: a synchronous write port for the ROM return path
// and an asynchronous read port for the display path.
module sprite_line_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 24,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sprite_fetch_sched.sv
// Shares one synchronous sprite ROM between two characters: fetches each sprite's
// next-line row into a line buffer at hblank start, then serves pixels from it.
module sprite_fetch_sched #(
    parameter int unsigned SPRITE_W = sprite_pkg::SPRITE_W,
    parameter int unsigned SPRITE_H = sprite_pkg::SPRITE_H,
    parameter int unsigned DATA_W   = sprite_pkg::DATA_W,
    parameter int unsigned V_TOTAL  = 525,
    parameter logic [DATA_W-1:0] KEY_RGB = sprite_pkg::KEY_RGB
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              line_start,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        SpriteX0,
    input  logic [9:0]        SpriteY0,
    input  logic [9:0]        SpriteX1,
    input  logic [9:0]        SpriteY1,
    input  logic [1:0]        Flip,
    output logic [7:0]        rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [1:0]        pix_on,
    output logic [DATA_W-1:0] pix_rgb0,
    output logic [DATA_W-1:0] pix_rgb1,
    output logic              busy,
    output logic              overrun
);
    import sprite_pkg::*;

    localparam int unsigned COL_W = $clog2(SPRITE_W);
    localparam int unsigned ROW_W = $clog2(SPRITE_H);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SPRITE_W - 1);

    fetch_state_t      state_q, state_d, eff_state;
    logic [COL_W-1:0]  col_q, col_d, rom_col;
    logic [1:0]        hit_q, hit_new, flip_q, row_valid_q, row_valid_d;
    logic [ROW_W-1:0]  row_q [2];
    logic [9:0]        sx_q [2];
    logic [9:0]        sy_in [2];
    logic [9:0]        next_y;
    coord_t            row_new [2];
    coord_t            dx [2];
    logic [DATA_W-1:0] rd [2];
    logic [DATA_W-1:0] pix_rgb [2];
    logic              start, issue, issue_sel;
    logic              wr_en_q, wr_sel_q;
    logic [COL_W-1:0]  wr_col_q;
    logic              overrun_q;

    assign start    = line_start && (state_q == IDLE);
    assign next_y   = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
    assign sy_in[0] = SpriteY0;
    assign sy_in[1] = SpriteY1;

    // A sprite that misses the line is skipped within the same cycle, no ROM slots spent.
    always_comb begin
        eff_state = state_q;
        if (eff_state == FETCH0 && !hit_q[0]) eff_state = FETCH1;
        if (eff_state == FETCH1 && !hit_q[1]) eff_state = DRAIN;
        state_d     = eff_state;
        col_d       = col_q;
        row_valid_d = row_valid_q;
        issue       = 1'b0;
        issue_sel   = 1'b0;
        unique case (eff_state)
            IDLE: begin
                if (start) begin
                    state_d     = FETCH0;
                    col_d       = '0;
                    row_valid_d = '0;
                end
            end
            FETCH0, FETCH1: begin
                issue     = 1'b1;
                issue_sel = (eff_state == FETCH1);
                col_d     = col_q + 1'b1;
                if (col_q == LAST_COL) state_d = (eff_state == FETCH0) ? FETCH1 : DRAIN;
            end
            DRAIN: begin
                row_valid_d = hit_q;
                state_d     = IDLE;
            end
        endcase
    end

    // Mirroring reverses the column via bit inversion; SPRITE_W is a power of 2.
    assign rom_col  = flip_q[issue_sel] ? ~col_q : col_q;
    assign rom_addr = issue ? 8'({row_q[issue_sel], rom_col}) : 8'd0;
    assign busy     = (state_q != IDLE);
    assign overrun  = overrun_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            hit_q       <= '0;
            flip_q      <= '0;
            row_valid_q <= '0;
            row_q[0]    <= '0;
            row_q[1]    <= '0;
            sx_q[0]     <= '0;
            sx_q[1]     <= '0;
            wr_en_q     <= 1'b0;
            wr_sel_q    <= 1'b0;
            wr_col_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_valid_q <= row_valid_d;
            wr_en_q     <= issue;
            wr_sel_q    <= issue_sel;
            wr_col_q    <= col_q;
            if (line_start && state_q != IDLE) overrun_q <= 1'b1;
            if (start) begin
                hit_q    <= hit_new;
                flip_q   <= Flip;
                row_q[0] <= row_new[0][ROW_W-1:0];
                row_q[1] <= row_new[1][ROW_W-1:0];
                sx_q[0]  <= SpriteX0;
                sx_q[1]  <= SpriteX1;
            end
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_sprite
        logic              on_q;
        logic [DATA_W-1:0] rgb_q;
        logic              in_range;

        assign row_new[i] = coord_diff(next_y, sy_in[i]);
        assign hit_new[i] = !row_new[i][10] && (row_new[i] < coord_t'(SPRITE_H));
        assign dx[i]      = coord_diff(DrawX, sx_q[i]);
        assign in_range   = !dx[i][10] && (dx[i] < coord_t'(SPRITE_W));

        sprite_line_buf #(
            .DEPTH(SPRITE_W),
            .WIDTH(DATA_W)
        ) u_buf (
            .clk  (Clk),
            .we   (wr_en_q && (wr_sel_q == 1'(i))),
            .waddr(wr_col_q),
            .wdata(rom_data),
            .raddr(dx[i][COL_W-1:0]),
            .rdata(rd[i])
        );

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                on_q  <= 1'b0;
                rgb_q <= '0;
            end else begin
                on_q  <= row_valid_q[i] && in_range && (rd[i] != KEY_RGB);
                rgb_q <= rd[i];
            end
        end

        assign pix_on[i]  = on_q;
        assign pix_rgb[i] = rgb_q;
    end

    assign pix_rgb0 = pix_rgb[0];
    assign pix_rgb1 = pix_rgb[1];

endmodule

// File: tb/tb_sprite_fetch_sched.sv
// Randomised bench for sprite_fetch_sched against a line-level reference model
// of the next-line fetch and the pixel lookup.
module tb_sprite_fetch_sched;

    localparam logic [23:0] KEY = 24'hFF00FF;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  DrawY = '0, DrawX = '0;
    logic [9:0]  SpriteX0 = '0, SpriteY0 = '0, SpriteX1 = '0, SpriteY1 = '0;
    logic [1:0]  Flip = '0;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data = '0;
    logic [1:0]  pix_on;
    logic [23:0] pix_rgb0, pix_rgb1;
    logic        busy, overrun;

    logic [23:0] rom_mem [256];
    logic [23:0] m_buf [2][16];
    bit          m_valid [2];
    int          m_sx [2];
    bit          m_ovr;
    int          n_checks = 0;
    int          n_pass = 0;

    sprite_fetch_sched dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .line_start(line_start),
        .DrawY     (DrawY),
        .DrawX     (DrawX),
        .SpriteX0  (SpriteX0),
        .SpriteY0  (SpriteY0),
        .SpriteX1  (SpriteX1),
        .SpriteY1  (SpriteY1),
        .Flip      (Flip),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pix_on    (pix_on),
        .pix_rgb0  (pix_rgb0),
        .pix_rgb1  (pix_rgb1),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #10 Clk = ~Clk;

    always @(posedge Clk) rom_data <= rom_mem[rom_addr];

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Fetch one line: expected address stream, busy window, then model buffers.
    task automatic run_line(input int dy, input int x0, input int y0, input int x1,
                            input int y1, input logic [1:0] fl, input int ovr_cyc,
                            input int rst_cyc);
        int ny, r, a, n;
        int sy [2];
        bit h [2];
        int addrs [$];
        ny = (dy == 524) ? 0 : dy + 1;
        sy[0] = y0;
        sy[1] = y1;
        for (int i = 0; i < 2; i++) begin
            r = ny - sy[i];
            h[i] = (r >= 0) && (r < 16);
            if (h[i]) begin
                for (int c = 0; c < 16; c++) begin
                    a = r * 16 + (fl[i] ? 15 - c : c);
                    addrs.push_back(a);
                    m_buf[i][c] = rom_mem[a];
                end
            end
        end
        m_sx[0] = x0;
        m_sx[1] = x1;
        n = addrs.size();
        DrawY = 10'(dy);
        SpriteX0 = 10'(x0);
        SpriteY0 = 10'(y0);
        SpriteX1 = 10'(x1);
        SpriteY1 = 10'(y1);
        Flip = fl;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        // Later input changes must not disturb the latched fetch.
        SpriteX0 = 10'($urandom);
        SpriteY0 = 10'($urandom);
        SpriteX1 = 10'($urandom);
        SpriteY1 = 10'($urandom);
        Flip = 2'($urandom);
        DrawY = 10'($urandom);
        for (int cyc = 1; cyc <= n + 2; cyc++) begin
            if (cyc == rst_cyc) begin
                Reset_n = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_overrun", overrun, 0);
                check("rst_pix_on", pix_on, 0);
                check("rst_rom_addr", rom_addr, 0);
                Reset_n = 1'b1;
                m_valid[0] = 0;
                m_valid[1] = 0;
                m_ovr = 0;
                return;
            end
            if (cyc <= n) check("rom_addr", rom_addr, addrs[cyc-1]);
            else check("rom_addr_idle", rom_addr, 0);
            check("busy", busy, (cyc <= n + 1) ? 1 : 0);
            if (cyc == ovr_cyc) begin
                line_start = 1'b1;
                m_ovr = 1;
            end
            tick();
            line_start = 1'b0;
        end
        m_valid[0] = h[0];
        m_valid[1] = h[1];
        check("overrun", overrun, m_ovr);
    endtask

    task automatic check_x(input int x);
        logic [9:0] xv;
        logic [1:0] exp_on;
        int dx [2];
        xv = 10'(x);
        DrawX = xv;
        tick();
        for (int i = 0; i < 2; i++) begin
            dx[i] = int'(xv) - m_sx[i];
            exp_on[i] = m_valid[i] && dx[i] >= 0 && dx[i] < 16 && m_buf[i][dx[i] & 15] != KEY;
        end
        check("pix_on", pix_on, exp_on);
        if (m_valid[0]) check("pix_rgb0", pix_rgb0, m_buf[0][dx[0] & 15]);
        if (m_valid[1]) check("pix_rgb1", pix_rgb1, m_buf[1][dx[1] & 15]);
    endtask

    task automatic sweep();
        for (int i = 0; i < 2; i++)
            for (int k = -2; k < 18; k++) check_x(m_sx[i] + k);
        for (int k = 0; k < 4; k++) check_x(int'($urandom_range(0, 799)));
    endtask

    function automatic int pick_y(input int ny);
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 1023));
        return (ny + 2 - int'($urandom_range(0, 19))) & 1023;
    endfunction

    initial begin
        int dy, ny;
        for (int i = 0; i < 256; i++) rom_mem[i] = 24'($urandom);
        rom_mem[5] = 24'h123456;
        rom_mem[10] = 24'hABCDEF;
        rom_mem[50] = 24'h000050;
        rom_mem[51] = KEY;
        rom_mem[52] = 24'h000052;
        m_valid[0] = 0;
        m_valid[1] = 0;
        m_sx[0] = 0;
        m_sx[1] = 0;
        m_ovr = 0;

        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        check("reset_rom_addr", rom_addr, 0);
        check("reset_pix_on", pix_on, 0);
        check("reset_pix_rgb0", pix_rgb0, 0);
        check("reset_pix_rgb1", pix_rgb1, 0);
        Reset_n = 1'b1;
        tick();

        run_line(99, 200, 100, 400, 300, 2'b00, -1, -1);
        sweep();
        check_x(205);
        check("plain_on", pix_on[0], 1);
        check("plain_rgb", pix_rgb0, 24'h123456);

        run_line(99, 200, 100, 400, 300, 2'b01, -1, -1);
        sweep();
        check_x(205);
        check("flip_rgb", pix_rgb0, 24'hABCDEF);

        run_line(99, 200, 300, 400, 10, 2'b00, -1, -1);
        sweep();

        run_line(524, 100, 400, 300, 0, 2'b00, -1, -1);
        sweep();

        run_line(52, 100, 50, 300, 50, 2'b00, -1, -1);
        check_x(103);
        check("key_off", pix_on[0], 0);
        check_x(102);
        check("key_left_on", pix_on[0], 1);
        check_x(104);
        check("key_right_on", pix_on[0], 1);

        run_line(99, 150, 100, 160, 95, 2'b10, 10, -1);
        sweep();

        run_line(99, 150, 100, 160, 95, 2'b00, -1, 20);
        sweep();

        for (int t = 0; t < 30; t++) begin
            dy = int'($urandom_range(0, 524));
            ny = (dy == 524) ? 0 : dy + 1;
            run_line(dy, int'($urandom_range(0, 660)), pick_y(ny),
                     int'($urandom_range(0, 660)), pick_y(ny), 2'($urandom), -1, -1);
            sweep();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_fetch_sched.md
# sprite_fetch_sched

Scheduler that owns the single synchronous sprite ROM shared by the two on-screen characters. At each horizontal-blank start it fetches the 16-pixel row of each sprite for the next scanline into two per-sprite line buffers. During active video it serves pixels from those buffers to the color mapper. It sits between the VGA controller and character position logic on one side, and the sprite ROM and color mapper on the other, replacing the two independent ROM instances.

## Interface
Parameters:
- SPRITE_W, 16: sprite width in pixels (power of 2).
- SPRITE_H, 16: sprite height in rows.
- DATA_W, 24: ROM word width, RGB888.
- V_TOTAL, 525: total lines per frame; DrawY wraps from V_TOTAL-1 to 0.
- KEY_RGB, 24'hFF00FF: transparent colour; pixels of this value are reported as off.

Ports:
- Clk  in  1: system clock, 50 MHz.
- Reset_n  in  1: asynchronous, active-low reset.
- line_start  in  1: one-Clk pulse at start of horizontal blank.
- DrawY  in  10: current scanline, sampled on line_start.
- DrawX  in  10: current pixel column, active video.
- SpriteX0, SpriteY0, SpriteX1, SpriteY1  in  10 each: top-left corner of each sprite.
- Flip  in  2: bit i set means sprite i is mirrored horizontally (facing left).
- rom_addr  out  8: sprite ROM address, row*SPRITE_W + col.
- rom_data  in  DATA_W: ROM output, valid exactly one Clk after rom_addr.
- pix_on  out  2: sprite i covers DrawX on this line and the pixel is not KEY_RGB.
- pix_rgb0, pix_rgb1  out  DATA_W: buffered pixel for each sprite.
- busy  out  1: fetch in progress.
- overrun  out  1: sticky; set when line_start arrives while busy.

## Operation
- States: IDLE, FETCH0, FETCH1, DRAIN.
- IDLE + line_start:
  - Latch next_y = (DrawY == V_TOTAL-1) ? 0 : DrawY+1.
  - Latch all sprite X/Y and Flip values.
  - Compute row_i = next_y - SpriteYi in 11-bit signed arithmetic; hit_i = 0 <= row_i < SPRITE_H.
  - Clear both row_valid bits and go to FETCH0.
- FETCH0: issue 16 addresses, col 0..15, one per Clk; rom col = Flip[0] ? 15-col : col. If !hit_0, skip directly to FETCH1 in the same cycle, with no ROM accesses.
- FETCH1: same as FETCH0 for sprite 1; skip to DRAIN if !hit_1.
- ROM return pipeline: rom_data captured one Clk after each address, written to buf_i[col]. DRAIN absorbs the last return, sets row_valid_i = hit_i, then goes to IDLE.
- Display path, registered, 1 Clk latency from DrawX:
  - dx_i = DrawX - latched SpriteXi, 11-bit signed.
  - pix_on[i] = row_valid_i && 0 <= dx_i < SPRITE_W && buf_i[dx_i] != KEY_RGB.
  - pix_rgb_i = buf_i[dx_i[3:0]].
- rom_addr holds 0 when not fetching.
- line_start while busy: ignored, overrun set to 1, and the current fetch completes normally.
- Sprite inputs changing mid-fetch: no effect, since values are latched.
- Partial offscreen sprites (X near 639, Y near 479) are handled purely by the signed range checks; no wrap of dx.

## Timing
- line_start at cycle 0 → busy high at cycle 1.
- Both sprites hit: addresses in cycles 1..32, last write in cycle 33, row_valid updated and busy low at cycle 34.
- One sprite hits: busy low at cycle 18. Neither hits: busy low at cycle 2.
- The 34-cycle worst case fits well inside horizontal blank (320 Clk at 50 MHz).
- Reset (any time, including mid-fetch): state IDLE, busy 0, overrun 0, rom_addr 0, row_valid 0, pix_on 0, pix_rgb 0. Buffer contents undefined but masked by row_valid.

## Structure
- Package sprite_pkg:
  - SPRITE_W, SPRITE_H, DATA_W, KEY_RGB.
  - fetch_state_t enum {IDLE, FETCH0, FETCH1, DRAIN}.
  - 11-bit signed coord type.
- Sub-module sprite_line_buf: 16 x DATA_W registers, one synchronous write port, one asynchronous read port. Instantiated twice.
- The ROM itself stays external, as a single instance.

## Test plan
- Sprite0 Y=100, X=200, Flip=0; DrawY=99, line_start → rom_addr 0..15 on cycles 1..16; busy low at cycle 34 only if sprite1 also hits, otherwise cycle 18; DrawX=205 gives pix_on[0]=1 and pix_rgb0=ROM[5].
- Same with Flip[0]=1 → rom_addr sequence 15..0; DrawX=205 gives ROM[10].
- Both sprites off the next line → no ROM accesses, busy low at cycle 2, pix_on=00 for all DrawX.
- DrawY=524 with SpriteY1=0 → next_y=0, sprite1 row 0 fetched, addresses 0..15.
- Second line_start at cycle 10 of a fetch → overrun=1 and the fetch completes unchanged. Reset_n low at cycle 20 → busy=0, overrun=0, pix_on=00 immediately.
- ROM word equal to KEY_RGB at col 3 → pix_on low at DrawX = SpriteX+3, high at neighbouring columns.
